// File: rtl/prbs_pkg.sv
// Shared PRBS polynomial definitions for the BERT transmitter and checker.
// Also holds the checker state encoding.
package prbs_pkg;

    localparam logic [2:0] TAPS_PRBS7  = 3'd0;
    localparam logic [2:0] TAPS_PRBS9  = 3'd1;
    localparam logic [2:0] TAPS_PRBS15 = 3'd2;
    localparam logic [2:0] TAPS_PRBS23 = 3'd3;
    localparam logic [2:0] TAPS_PRBS31 = 3'd4;

    localparam int unsigned N_PRBS7  = 7;
    localparam int unsigned M_PRBS7  = 6;
    localparam int unsigned N_PRBS9  = 9;
    localparam int unsigned M_PRBS9  = 5;
    localparam int unsigned N_PRBS15 = 15;
    localparam int unsigned M_PRBS15 = 14;
    localparam int unsigned N_PRBS23 = 23;
    localparam int unsigned M_PRBS23 = 18;
    localparam int unsigned N_PRBS31 = 31;
    localparam int unsigned M_PRBS31 = 28;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    // Index of s[n-1]; unused encodings fall back to PRBS7.
    function automatic logic [4:0] poly_hi(input logic [2:0] taps);
        case (taps)
            TAPS_PRBS9:  poly_hi = 5'(N_PRBS9 - 1);
            TAPS_PRBS15: poly_hi = 5'(N_PRBS15 - 1);
            TAPS_PRBS23: poly_hi = 5'(N_PRBS23 - 1);
            TAPS_PRBS31: poly_hi = 5'(N_PRBS31 - 1);
            default:     poly_hi = 5'(N_PRBS7 - 1);
        endcase
    endfunction

    function automatic logic [4:0] poly_lo(input logic [2:0] taps);
        case (taps)
            TAPS_PRBS9:  poly_lo = 5'(M_PRBS9 - 1);
            TAPS_PRBS15: poly_lo = 5'(M_PRBS15 - 1);
            TAPS_PRBS23: poly_lo = 5'(M_PRBS23 - 1);
            TAPS_PRBS31: poly_lo = 5'(M_PRBS31 - 1);
            default:     poly_lo = 5'(M_PRBS7 - 1);
        endcase
    endfunction

    // Bytes needed to fill n bits of state: ceil(n/8).
    function automatic logic [2:0] seed_bytes(input logic [2:0] taps);
        case (taps)
            TAPS_PRBS9:  seed_bytes = 3'd2;
            TAPS_PRBS15: seed_bytes = 3'd2;
            TAPS_PRBS23: seed_bytes = 3'd3;
            TAPS_PRBS31: seed_bytes = 3'd4;
            default:     seed_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational 8-bit Fibonacci LFSR step, bit 7 first. In seed mode the
// received bits are shifted in instead of the feedback bits.
module prbs_step
    import prbs_pkg::*;
(
    input  logic [30:0] state,
    input  logic [2:0]  taps,
    input  logic [7:0]  din,
    input  logic        seed,
    output logic [30:0] next_state,
    output logic [7:0]  expected
);

    logic [4:0]  hi;
    logic [4:0]  lo;
    logic [30:0] s;
    logic        fb;

    assign hi = poly_hi(taps);
    assign lo = poly_lo(taps);

    always_comb begin
        s        = state;
        fb       = 1'b0;
        expected = '0;
        for (int i = 0; i < 8; i++) begin
            fb            = s[hi] ^ s[lo];
            expected[7-i] = fb;
            s             = {s[29:0], seed ? din[7-i] : fb};
        end
        next_state = s;
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for the sequence, verifies it, then
// counts compared and errored bits and drops lock on a burst of errors.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned VERIFY_BYTES = 4,
    parameter int unsigned WINDOW_BYTES = 64,
    parameter int unsigned LOSS_THRESH  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  taps,
    input  logic        restart,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        locked,
    output logic [7:0]  error,
    output logic [31:0] bit_count,
    output logic [31:0] error_count,
    output logic [7:0]  sync_loss
);

    localparam int unsigned VER_W = $clog2(VERIFY_BYTES + 1);
    localparam int unsigned WIN_W = $clog2(WINDOW_BYTES + 1);
    localparam int unsigned ERR_W = $clog2(LOSS_THRESH + 9);

    localparam logic [VER_W-1:0] VER_LAST = VER_W'(VERIFY_BYTES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_BYTES - 1);
    localparam logic [ERR_W-1:0] LOSS_LIM = ERR_W'(LOSS_THRESH);

    logic [1:0]       state_q, state_d;
    logic [30:0]      lfsr_q, lfsr_d, lfsr_next;
    logic [2:0]       taps_q;
    logic [2:0]       seed_q, seed_d;
    logic [VER_W-1:0] ver_q, ver_d;
    logic [WIN_W-1:0] win_bytes_q, win_bytes_d;
    logic [ERR_W-1:0] win_err_q, win_err_d, win_err_sum;
    logic [7:0]       error_q, error_d;
    logic [31:0]      bit_count_q, bit_count_d;
    logic [31:0]      error_count_q, error_count_d;
    logic [7:0]       sync_loss_q, sync_loss_d;
    logic [7:0]       expected, diff;
    logic [3:0]       pc;
    logic [32:0]      bc_sum, ec_sum;

    prbs_step u_step (
        .state      (lfsr_q),
        .taps       (taps),
        .din        (data_in),
        .seed       (state_q == HUNT),
        .next_state (lfsr_next),
        .expected   (expected)
    );

    always_comb begin
        diff = data_in ^ expected;
        pc   = '0;
        for (int i = 0; i < 8; i++) pc = pc + {3'b000, diff[i]};
        win_err_sum = win_err_q + ERR_W'(pc);
        bc_sum      = {1'b0, bit_count_q} + 33'd8;
        ec_sum      = {1'b0, error_count_q} + {29'd0, pc};

        state_d       = state_q;
        lfsr_d        = lfsr_q;
        seed_d        = seed_q;
        ver_d         = ver_q;
        win_bytes_d   = win_bytes_q;
        win_err_d     = win_err_q;
        error_d       = error_q;
        bit_count_d   = bit_count_q;
        error_count_d = error_count_q;
        sync_loss_d   = sync_loss_q;

        // A polynomial switch invalidates everything gathered so far.
        if (restart || (taps != taps_q)) begin
            state_d       = HUNT;
            seed_d        = '0;
            ver_d         = '0;
            win_bytes_d   = '0;
            win_err_d     = '0;
            error_d       = '0;
            bit_count_d   = '0;
            error_count_d = '0;
            sync_loss_d   = '0;
        end else if (data_valid) begin
            case (state_q)
                HUNT: begin
                    lfsr_d  = lfsr_next;
                    error_d = '0;
                    if (seed_q == seed_bytes(taps) - 3'd1) begin
                        state_d = VERIFY;
                        seed_d  = '0;
                        ver_d   = '0;
                    end else begin
                        seed_d = seed_q + 3'd1;
                    end
                end
                VERIFY: begin
                    lfsr_d  = lfsr_next;
                    error_d = diff;
                    if (diff != 8'h00) begin
                        state_d = HUNT;
                        seed_d  = '0;
                    end else if (ver_q == VER_LAST) begin
                        state_d     = LOCKED;
                        win_bytes_d = '0;
                        win_err_d   = '0;
                    end else begin
                        ver_d = ver_q + 1'b1;
                    end
                end
                LOCKED: begin
                    lfsr_d        = lfsr_next;
                    error_d       = diff;
                    bit_count_d   = bc_sum[32] ? 32'hFFFF_FFFF : bc_sum[31:0];
                    error_count_d = ec_sum[32] ? 32'hFFFF_FFFF : ec_sum[31:0];
                    if (win_err_sum >= LOSS_LIM) begin
                        state_d     = HUNT;
                        seed_d      = '0;
                        win_bytes_d = '0;
                        win_err_d   = '0;
                        if (sync_loss_q != 8'hFF) sync_loss_d = sync_loss_q + 8'd1;
                    end else if (win_bytes_q == WIN_LAST) begin
                        win_bytes_d = '0;
                        win_err_d   = '0;
                    end else begin
                        win_bytes_d = win_bytes_q + 1'b1;
                        win_err_d   = win_err_sum;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= HUNT;
            lfsr_q        <= '0;
            taps_q        <= '0;
            seed_q        <= '0;
            ver_q         <= '0;
            win_bytes_q   <= '0;
            win_err_q     <= '0;
            error_q       <= '0;
            bit_count_q   <= '0;
            error_count_q <= '0;
            sync_loss_q   <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            taps_q        <= taps;
            seed_q        <= seed_d;
            ver_q         <= ver_d;
            win_bytes_q   <= win_bytes_d;
            win_err_q     <= win_err_d;
            error_q       <= error_d;
            bit_count_q   <= bit_count_d;
            error_count_q <= error_count_d;
            sync_loss_q   <= sync_loss_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign error       = error_q;
    assign bit_count   = bit_count_q;
    assign error_count = error_count_q;
    assign sync_loss   = sync_loss_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a local PRBS transmitter model feeds the
// checker and each task checks hand-derived lock timing and counter values.
module tb_prbs_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  taps;
    logic        restart;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        locked;
    logic [7:0]  error;
    logic [31:0] bit_count;
    logic [31:0] error_count;
    logic [7:0]  sync_loss;

    int total = 0;
    int bad   = 0;

    logic [30:0] g;
    int          gh;
    int          gl;

    always #5 clock = ~clock;

    // Threshold of 16 means one fully inverted byte stays locked, the second drops it.
    prbs_checker #(
        .VERIFY_BYTES (4),
        .WINDOW_BYTES (64),
        .LOSS_THRESH  (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .taps        (taps),
        .restart     (restart),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .locked      (locked),
        .error       (error),
        .bit_count   (bit_count),
        .error_count (error_count),
        .sync_loss   (sync_loss)
    );

    task automatic gen_byte(output logic [7:0] b);
        logic nb;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            nb     = g[gh] ^ g[gl];
            g      = {g[29:0], nb};
            b[7-i] = nb;
        end
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    task automatic tx(input logic [7:0] mask);
        logic [7:0] b;
        gen_byte(b);
        data_in    = b ^ mask;
        data_valid = 1'b1;
        @(posedge clock);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic set_poly(input logic [2:0] t);
        taps = t;
        case (t)
            3'd1:    begin gh = 8;  gl = 4;  end
            3'd2:    begin gh = 14; gl = 13; end
            3'd3:    begin gh = 22; gl = 17; end
            3'd4:    begin gh = 30; gl = 27; end
            default: begin gh = 6;  gl = 5;  end
        endcase
        g       = 31'h7FFF_FFFF;
        restart = 1'b1;
        idle();
        restart = 1'b0;
        idle();
    endtask

    task automatic test_reset();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got %0h want 0", locked); end
        total++; if (error !== 8'h00) begin bad++; $display("FAIL reset_error got %0h want 0", error); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL reset_bits got %0d want 0", bit_count); end
        total++; if (error_count !== 32'd0) begin bad++; $display("FAIL reset_errs got %0d want 0", error_count); end
        total++; if (sync_loss !== 8'd0) begin bad++; $display("FAIL reset_sync got %0d want 0", sync_loss); end
    endtask

    task automatic test_prbs7_lock();
        for (int k = 0; k < 4; k++) tx(8'h00);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL p7_early_lock got %0h want 0", locked); end
        tx(8'h00);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p7_lock got %0h want 1", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL p7_bits_at_lock got %0d want 0", bit_count); end
        for (int k = 0; k < 100; k++) tx(8'h00);
        total++; if (bit_count !== 32'd800) begin bad++; $display("FAIL p7_bits got %0d want 800", bit_count); end
        total++; if (error_count !== 32'd0) begin bad++; $display("FAIL p7_errs got %0d want 0", error_count); end
        total++; if (error !== 8'h00) begin bad++; $display("FAIL p7_error got %0h want 0", error); end
    endtask

    task automatic test_single_flip();
        set_poly(3'd2);
        for (int k = 0; k < 6; k++) tx(8'h00);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p15_lock got %0h want 1", locked); end
        tx(8'h08);
        total++; if (error !== 8'h08) begin bad++; $display("FAIL flip_error got %0h want 08", error); end
        total++; if (error_count !== 32'd1) begin bad++; $display("FAIL flip_errs got %0d want 1", error_count); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL flip_locked got %0h want 1", locked); end
        tx(8'h00);
        total++; if (error !== 8'h00) begin bad++; $display("FAIL flip_next_error got %0h want 0", error); end
        total++; if (bit_count !== 32'd16) begin bad++; $display("FAIL flip_bits got %0d want 16", bit_count); end
    endtask

    task automatic test_sync_loss();
        set_poly(3'd0);
        for (int k = 0; k < 5; k++) tx(8'h00);
        tx(8'hFF);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_first_locked got %0h want 1", locked); end
        total++; if (error_count !== 32'd8) begin bad++; $display("FAIL loss_first_errs got %0d want 8", error_count); end
        tx(8'hFF);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_locked got %0h want 0", locked); end
        total++; if (sync_loss !== 8'd1) begin bad++; $display("FAIL loss_sync got %0d want 1", sync_loss); end
        total++; if (error_count !== 32'd16) begin bad++; $display("FAIL loss_errs got %0d want 16", error_count); end
        for (int k = 0; k < 4; k++) tx(8'h00);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early got %0h want 0", locked); end
        tx(8'h00);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock got %0h want 1", locked); end
        total++; if (bit_count !== 32'd16) begin bad++; $display("FAIL relock_bits got %0d want 16", bit_count); end
    endtask

    task automatic test_restart();
        for (int k = 0; k < 3; k++) tx(8'h00);
        total++; if (bit_count !== 32'd40) begin bad++; $display("FAIL pre_restart_bits got %0d want 40", bit_count); end
        restart = 1'b1;
        tx(8'h00);
        restart = 1'b0;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL restart_locked got %0h want 0", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL restart_bits got %0d want 0", bit_count); end
        total++; if (error_count !== 32'd0) begin bad++; $display("FAIL restart_errs got %0d want 0", error_count); end
        total++; if (sync_loss !== 8'd0) begin bad++; $display("FAIL restart_sync got %0d want 0", sync_loss); end
    endtask

    task automatic test_verify_error();
        set_poly(3'd0);
        tx(8'h00);
        tx(8'h00);
        tx(8'h01);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL verr_locked got %0h want 0", locked); end
        for (int k = 0; k < 4; k++) tx(8'h00);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL verr_early got %0h want 0", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL verr_bits got %0d want 0", bit_count); end
        tx(8'h00);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL verr_lock got %0h want 1", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL verr_bits_lock got %0d want 0", bit_count); end
    endtask

    task automatic test_prbs31_gapped();
        set_poly(3'd4);
        for (int k = 1; k <= 8; k++) begin
            tx(8'h00);
            if (k == 7) begin
                total++; if (locked !== 1'b0) begin bad++; $display("FAIL p31_early got %0h want 0", locked); end
            end
            if (k == 8) begin
                total++; if (locked !== 1'b1) begin bad++; $display("FAIL p31_lock got %0h want 1", locked); end
            end
            idle();
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL p31_idle_lock got %0h want 1", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL p31_idle_bits got %0d want 0", bit_count); end
        for (int k = 1; k <= 3; k++) begin
            tx(8'h00);
            idle();
            total++; if (bit_count !== 32'(8 * k)) begin bad++; $display("FAIL p31_gap_bits got %0d want %0d", bit_count, 8 * k); end
            total++; if (error !== 8'h00) begin bad++; $display("FAIL p31_gap_error got %0h want 0", error); end
        end
    endtask

    task automatic test_taps_change();
        set_poly(3'd0);
        for (int k = 0; k < 7; k++) tx(8'h00);
        total++; if (bit_count !== 32'd16) begin bad++; $display("FAIL tc_pre_bits got %0d want 16", bit_count); end
        taps = 3'd4;
        tx(8'h00);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL tc_locked got %0h want 0", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL tc_bits got %0d want 0", bit_count); end
        total++; if (error_count !== 32'd0) begin bad++; $display("FAIL tc_errs got %0d want 0", error_count); end
    endtask

    task automatic test_async_reset();
        set_poly(3'd0);
        for (int k = 0; k < 7; k++) tx(8'h00);
        tx(8'h01);
        total++; if (error !== 8'h01) begin bad++; $display("FAIL ar_pre_error got %0h want 01", error); end
        total++; if (bit_count !== 32'd24) begin bad++; $display("FAIL ar_pre_bits got %0d want 24", bit_count); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL ar_locked got %0h want 0", locked); end
        total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL ar_bits got %0d want 0", bit_count); end
        total++; if (error_count !== 32'd0) begin bad++; $display("FAIL ar_errs got %0d want 0", error_count); end
        total++; if (error !== 8'h00) begin bad++; $display("FAIL ar_error got %0h want 0", error); end
        idle();
        reset = 1'b1;
        idle();
    endtask

    initial begin
        reset      = 1'b0;
        taps       = 3'd0;
        restart    = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        gh         = 6;
        gl         = 5;
        g          = 31'h7FFF_FFFF;
        repeat (3) idle();
        reset = 1'b1;
        idle();
        test_reset();
        test_prbs7_lock();
        test_single_flip();
        test_sync_loss();
        test_restart();
        test_verify_error();
        test_prbs31_gapped();
        test_taps_change();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side PRBS checker for the bit error ratio tester. It consumes the 8-bit stream produced by the PRBS transmitter after the mux and error-injection stage, and self-synchronises a local LFSR to that stream. Once locked, it compares every received byte against the locally generated expected byte and accumulates bit and error counts for BER computation. It also detects loss of synchronisation and re-hunts automatically.

## Interface
Parameters:
- VERIFY_BYTES, 4: consecutive error-free bytes required in VERIFY before declaring lock.
- WINDOW_BYTES, 64: length of the loss-of-lock monitoring window, in valid bytes.
- LOSS_THRESH, 8: errored bits within one window that force loss of lock.

Ports:
- clock, input, 1: single clock; all logic is rising-edge.
- reset, input, 1: asynchronous, active-low reset.
- taps, input, 3: polynomial select, unsigned. 0 = PRBS7 (x^7+x^6+1), 1 = PRBS9 (x^9+x^5+1), 2 = PRBS15 (x^15+x^14+1), 3 = PRBS23 (x^23+x^18+1), 4 = PRBS31 (x^31+x^28+1). Values 5–7 select PRBS7.
- restart, input, 1: synchronous. Forces HUNT and clears all counters.
- data_in, input, 8: received byte. Bit 7 is first in time.
- data_valid, input, 1: data_in is valid this cycle.
- locked, output, 1: high in LOCKED state.
- error, output, 8: per-bit mismatch of the last compared byte, equal to data_in XOR expected.
- bit_count, output, 32: bits compared while LOCKED.
- error_count, output, 32: errored bits while LOCKED.
- sync_loss, output, 8: number of LOCKED→HUNT transitions.

## Operation
- LFSR model, Fibonacci form. Per bit: new = s[n-1] ^ s[m-1]; the state shifts left and new enters s[0]; the transmitted bit is new. The state register is 31 bits; only the low n bits are used.
- An 8-bit step applies the single-bit update eight times, starting with bit 7.
- State HUNT:
  - Each valid byte is shifted into the state as received bits. No comparison is made.
  - After SEED = ceil(n/8) valid bytes (1, 2, 2, 3, 4 for taps 0–4), the block goes to VERIFY.
- State VERIFY:
  - The expected byte comes from the state.
  - The state advances from its own value; received data is not fed back.
  - Any nonzero error returns the block to HUNT and restarts the seed count.
  - VERIFY_BYTES consecutive clean bytes move the block to LOCKED.
- State LOCKED:
  - Per valid byte: bit_count += 8, and error_count += popcount(error).
  - The window byte counter and the window error sum both advance.
  - Window error sum ≥ LOSS_THRESH, including errors from the current byte, moves the block to HUNT and increments sync_loss. This check applies at any point in the window.
  - When WINDOW_BYTES bytes complete without a trigger, both window counters clear.
- error updates on every valid byte in VERIFY and LOCKED. It reads 0 in HUNT.
- Counters saturate: bit_count and error_count at 0xFFFFFFFF, sync_loss at 0xFF. Saturation never wraps.
- restart, or a change of taps from the value sampled at the previous cycle:
  - next state is HUNT;
  - bit_count, error_count, sync_loss, window counters and seed count all clear;
  - a byte valid in that same cycle is discarded.
- Cycles with data_valid low do not change state, LFSR or counters.

## Timing
- Reset (reset low) sets state HUNT, LFSR state 0, locked 0, error 0, all counts 0, and the window and seed counters 0.
- All outputs are registered. A byte valid in cycle k updates error, counts and state at the edge ending cycle k, so the update is visible in cycle k+1.
- Lock latency from reset on an error-free stream: SEED + VERIFY_BYTES valid bytes. locked rises in the cycle after the last verify byte. For PRBS7 with defaults this is 5 bytes.
- Loss of lock: locked falls in the cycle after the triggering byte. That byte's errors are still counted.
- Reset asserted mid-operation clears everything immediately, with no wait for an edge.

## Structure
- Package prbs_pkg holds:
  - the taps encodings;
  - constants for polynomial length n and tap m per encoding;
  - SEED bytes per encoding;
  - the state enum HUNT/VERIFY/LOCKED.
- The transmitter imports the same package so both ends share the polynomial definitions.
- Sub-module prbs_step is combinational. It takes 31-bit state, taps and an 8-bit input, plus a seed/free-run select, and returns the next state and the expected byte. It is instantiated once.
- The top holds the FSM, the counters and popcount.

## Test plan
- Error-free PRBS7 from the transmitter, continuous valid: locked = 1 after byte 5. After 100 further bytes: bit_count = 800, error_count = 0, error = 0.
- Locked PRBS15 with one flipped bit (0x08 XOR): that cycle error = 0x08. error_count = 1 and locked stays 1. The next byte shows error = 0.
- Locked PRBS7 followed by two bytes XOR 0xFF: sync_loss = 1 and locked falls after the second byte, with error_count = 16. With a clean stream afterwards, the block relocks after 5 more bytes.
- An error injected during VERIFY (byte 3) returns the block to HUNT. locked rises only after 5 clean bytes from the next one, and bit_count stays 0 until lock.
- PRBS31 with data_valid toggling every other cycle: locked after 8 valid bytes. Idle cycles leave all outputs unchanged.
- restart asserted together with a valid byte while LOCKED: next cycle locked = 0 and all counts = 0, and the byte is not counted. A taps change 0→4 behaves identically. Asserting reset mid-lock clears the outputs asynchronously.
